// File: rtl/xfipcs_async_qual.sv
// xfipcs_async_qual
// Level qualifier placed after the two-flop synchronizer. A new level on
// sync_in is accepted only after FILTER_LEN consecutive matching samples.
// Produces a filtered level, one-cycle rise/fall pulses and saturating
// counters of accepted transitions and aborted qualifications.
module xfipcs_async_qual #(
  parameter int FILTER_LEN = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int GLT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_in,
  input  logic                 clr_cnt,
  output logic                 level_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] chg_cnt,
  output logic [GLT_WIDTH-1:0] glt_cnt
);

  // qcnt holds 0..FILTER_LEN-1, so ceil(log2(FILTER_LEN)) bits suffice
  localparam int QW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [QW-1:0]        QMAX    = QW'(FILTER_LEN - 1);
  localparam logic [QW-1:0]        QONE    = QW'(1);
  localparam logic [CNT_WIDTH-1:0] CHG_ONE = CNT_WIDTH'(1);
  localparam logic [GLT_WIDTH-1:0] GLT_ONE = GLT_WIDTH'(1);

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    LOW_QUAL    = 2'd1,
    HIGH_STABLE = 2'd2,
    HIGH_QUAL   = 2'd3
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic          accept;
  logic          abort;

  // Decode this cycle's counter events from the current state and sample
  always_comb begin
    accept = 1'b0;
    abort  = 1'b0;
    case (state)
      LOW_QUAL: begin
        accept = sync_in && (qcnt == QMAX);
        abort  = !sync_in;
      end
      HIGH_QUAL: begin
        accept = !sync_in && (qcnt == QMAX);
        abort  = sync_in;
      end
      default: begin
        accept = 1'b0;
        abort  = 1'b0;
      end
    endcase
  end

  // Qualification FSM with registered level and event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOW_STABLE;
      qcnt       <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        LOW_STABLE: begin
          if (sync_in) begin
            state <= LOW_QUAL;
            qcnt  <= QONE;
          end
        end
        LOW_QUAL: begin
          if (!sync_in) begin
            state <= LOW_STABLE;
            qcnt  <= '0;
          end else if (qcnt == QMAX) begin
            state      <= HIGH_STABLE;
            qcnt       <= '0;
            level_out  <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            qcnt <= qcnt + QONE;
          end
        end
        HIGH_STABLE: begin
          if (!sync_in) begin
            state <= HIGH_QUAL;
            qcnt  <= QONE;
          end
        end
        HIGH_QUAL: begin
          if (sync_in) begin
            state <= HIGH_STABLE;
            qcnt  <= '0;
          end else if (qcnt == QMAX) begin
            state      <= LOW_STABLE;
            qcnt       <= '0;
            level_out  <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            qcnt <= qcnt + QONE;
          end
        end
        default: begin
          state <= LOW_STABLE;
          qcnt  <= '0;
        end
      endcase
    end
  end

  // Saturating transition counter; a clear wins over a same-cycle event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_cnt <= '0;
    end else if (clr_cnt) begin
      chg_cnt <= '0;
    end else if (accept && (chg_cnt != {CNT_WIDTH{1'b1}})) begin
      chg_cnt <= chg_cnt + CHG_ONE;
    end
  end

  // Saturating glitch counter; a clear wins over a same-cycle event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glt_cnt <= '0;
    end else if (clr_cnt) begin
      glt_cnt <= '0;
    end else if (abort && (glt_cnt != {GLT_WIDTH{1'b1}})) begin
      glt_cnt <= glt_cnt + GLT_ONE;
    end
  end

endmodule

// File: tb/tb_xfipcs_async_qual.sv
// Bench for xfipcs_async_qual: two instances (FILTER_LEN=8 with 4-bit
// counters, FILTER_LEN=2 with default widths) share one stimulus stream and
// are compared every cycle against a run-length reference model.
module tb_xfipcs_async_qual;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sync_in = 1'b0;
  logic clr_cnt = 1'b0;

  logic        level_a, rise_a, fall_a;
  logic [3:0]  chg_a, glt_a;
  logic        level_b, rise_b, fall_b;
  logic [15:0] chg_b;
  logic [7:0]  glt_b;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state, index 0 = FILTER_LEN 8, index 1 = FILTER_LEN 2
  int fl[2]   = '{8, 2};
  int cmax[2] = '{15, 65535};
  int gmax[2] = '{15, 255};
  int m_lvl[2], m_run[2], m_chg[2], m_glt[2], m_rise[2], m_fall[2];
  int rise_seen_a, fall_seen_a, rise_seen_b, fall_seen_b;

  always #5 clk = ~clk;

  xfipcs_async_qual #(.FILTER_LEN(8), .CNT_WIDTH(4), .GLT_WIDTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .sync_in(sync_in), .clr_cnt(clr_cnt),
    .level_out(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .chg_cnt(chg_a), .glt_cnt(glt_a)
  );

  xfipcs_async_qual #(.FILTER_LEN(2), .CNT_WIDTH(16), .GLT_WIDTH(8)) u_dut_b (
    .clk(clk), .rst(rst), .sync_in(sync_in), .clr_cnt(clr_cnt),
    .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .chg_cnt(chg_b), .glt_cnt(glt_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 0; m_run[i] = 0; m_chg[i] = 0;
      m_glt[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
    end
  endtask

  // One sample: count consecutive samples differing from the accepted level;
  // FILTER_LEN of them flips the level, a shorter run cut off is a glitch.
  task automatic model_step(input int s, input int c);
    for (int i = 0; i < 2; i++) begin
      int ev_chg, ev_glt;
      ev_chg = 0; ev_glt = 0;
      m_rise[i] = 0; m_fall[i] = 0;
      if (s != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == fl[i]) begin
          m_lvl[i]  = s;
          m_rise[i] = (s == 1) ? 1 : 0;
          m_fall[i] = (s == 0) ? 1 : 0;
          m_run[i]  = 0;
          ev_chg    = 1;
        end
      end else if (m_run[i] > 0) begin
        ev_glt   = 1;
        m_run[i] = 0;
      end
      if (c != 0) begin
        m_chg[i] = 0; m_glt[i] = 0;
      end else begin
        if (ev_chg != 0 && m_chg[i] < cmax[i]) m_chg[i]++;
        if (ev_glt != 0 && m_glt[i] < gmax[i]) m_glt[i]++;
      end
    end
  endtask

  task automatic compare_all();
    check("level_a", int'(level_a), m_lvl[0]);
    check("rise_a",  int'(rise_a),  m_rise[0]);
    check("fall_a",  int'(fall_a),  m_fall[0]);
    check("chg_a",   int'(chg_a),   m_chg[0]);
    check("glt_a",   int'(glt_a),   m_glt[0]);
    check("level_b", int'(level_b), m_lvl[1]);
    check("rise_b",  int'(rise_b),  m_rise[1]);
    check("fall_b",  int'(fall_b),  m_fall[1]);
    check("chg_b",   int'(chg_b),   m_chg[1]);
    check("glt_b",   int'(glt_b),   m_glt[1]);
  endtask

  task automatic step(input int s, input int c);
    sync_in = s[0];
    clr_cnt = c[0];
    @(posedge clk);
    #1;
    model_step(s, c);
    compare_all();
    rise_seen_a += int'(rise_a); fall_seen_a += int'(fall_a);
    rise_seen_b += int'(rise_b); fall_seen_b += int'(fall_b);
  endtask

  task automatic run(input int s, input int len);
    for (int k = 0; k < len; k++) step(s, 0);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear without a clock edge
  task automatic async_reset();
    rst = 1'b1;
    #1;
    check("rst_level_a", int'(level_a), 0);
    check("rst_rise_a",  int'(rise_a),  0);
    check("rst_fall_a",  int'(fall_a),  0);
    check("rst_chg_a",   int'(chg_a),   0);
    check("rst_glt_a",   int'(glt_a),   0);
    check("rst_level_b", int'(level_b), 0);
    check("rst_chg_b",   int'(chg_b),   0);
    check("rst_glt_b",   int'(glt_b),   0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rise_seen_a = 0; fall_seen_a = 0; rise_seen_b = 0; fall_seen_b = 0;
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // rise/fall qualification
    step(0, 1);
    run(0, 5);
    rise_seen_a = 0; fall_seen_a = 0;
    run(1, 20);
    run(0, 20);
    check("rf_rise_count", rise_seen_a, 1);
    check("rf_fall_count", fall_seen_a, 1);
    check("rf_chg", int'(chg_a), 2);
    check("rf_glt", int'(glt_a), 0);

    // glitch rejection: high runs 1, 7, 7 with 3-cycle low gaps
    step(0, 1);
    rise_seen_a = 0; fall_seen_a = 0;
    run(1, 1); run(0, 3);
    run(1, 7); run(0, 3);
    run(1, 7); run(0, 3);
    check("gl_level", int'(level_a), 0);
    check("gl_pulses", rise_seen_a + fall_seen_a, 0);
    check("gl_glt", int'(glt_a), 3);
    check("gl_chg", int'(chg_a), 0);
    run(1, 8);
    check("gl_accept_chg", int'(chg_a), 1);
    check("gl_accept_level", int'(level_a), 1);
    run(0, 10);

    // saturation: 20 accepted transitions, then 20 glitches
    step(0, 1);
    for (int k = 0; k < 10; k++) begin
      run(1, 10);
      run(0, 10);
    end
    check("sat_chg", int'(chg_a), 15);
    for (int k = 0; k < 20; k++) begin
      run(1, 1);
      run(0, 2);
    end
    check("sat_glt", int'(glt_a), 15);
    check("sat_chg_hold", int'(chg_a), 15);

    // clear on the accepting edge of a rise
    run(0, 4);
    run(1, 7);
    step(1, 1);
    check("clr_chg", int'(chg_a), 0);
    check("clr_rise", int'(rise_a), 1);
    check("clr_level", int'(level_a), 1);
    run(0, 8);
    check("clr_next_chg", int'(chg_a), 1);

    // minimum filter: 1-cycle alternation is all glitches, 2-cycle follows
    run(0, 4);
    step(0, 1);
    rise_seen_b = 0; fall_seen_b = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0);
      step(0, 0);
    end
    check("mf1_level", int'(level_b), 0);
    check("mf1_pulses", rise_seen_b + fall_seen_b, 0);
    check("mf1_glt", int'(glt_b), 10);
    rise_seen_b = 0; fall_seen_b = 0;
    for (int k = 0; k < 6; k++) begin
      run(1, 2);
      run(0, 2);
    end
    check("mf2_rise", rise_seen_b, 6);
    check("mf2_fall", fall_seen_b, 6);

    // reset mid-qualification with sync_in held high
    run(0, 10);
    run(1, 5);
    async_reset();
    run(1, 7);
    check("rst_lat_before", int'(level_a), 0);
    step(1, 0);
    check("rst_lat_at8", int'(level_a), 1);
    check("rst_lat_rise", int'(rise_a), 1);

    // randomized runs with occasional clears and one mid-run reset
    for (int r = 0; r < 300; r++) begin
      int v, len;
      v   = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 11));
      if (r == 150) async_reset();
      for (int k = 0; k < len; k++)
        step(v, ($urandom_range(0, 39) == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
